// File: rtl/mix_columns_seq.sv
// Iterative AES-128 MixColumns stage: mixes COLS_PER_CYCLE columns per clock between
// ShiftRows and AddRoundKey, with valid/ready handshakes on both sides.

module mul_by_2 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // xtime in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1
  assign y = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
endmodule

module mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         bypass,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int unsigned STATE_W  = 128;
  localparam int unsigned COL_W    = 32;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned CNT_W    = 3;

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   col_cnt;
  logic [COL_W-1:0]   work_cols   [NUM_COLS];
  logic [COL_W-1:0]   result_cols [NUM_COLS];
  logic [COL_W-1:0]   mixed       [COLS_PER_CYCLE];
  logic [1:0]         mix_idx     [COLS_PER_CYCLE];
  logic               last_group;

  assign last_group = (col_cnt + CNT_W'(COLS_PER_CYCLE)) == CNT_W'(NUM_COLS);

  // One mixing lane per column handled in a cycle
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
    logic [1:0] idx;
    logic [7:0] a  [4];
    logic [7:0] x2 [4];

    assign idx = 2'(col_cnt + CNT_W'(k));

    for (genvar r = 0; r < 4; r++) begin : g_byte
      assign a[r] = work_cols[idx][31-8*r -: 8];
      mul_by_2 u_mul (.a(a[r]), .y(x2[r]));
    end

    // 3a is formed as xtime(a)^a
    assign mixed[k] = {x2[0] ^ x2[1] ^ a[1] ^ a[2] ^ a[3],
                       a[0] ^ x2[1] ^ x2[2] ^ a[2] ^ a[3],
                       a[0] ^ a[1] ^ x2[2] ^ x2[3] ^ a[3],
                       x2[0] ^ a[0] ^ a[1] ^ a[2] ^ x2[3]};
    assign mix_idx[k] = idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)   next_state = bypass ? DONE : BUSY;
      BUSY:    if (last_group) next_state = DONE;
      DONE:    if (out_ready)  next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      BUSY:    busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  // Work register is sampled once on accept; results fill column slots as they are mixed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
        work_cols[c]   <= '0;
        result_cols[c] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            col_cnt <= '0;
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
              work_cols[c] <= state_in[STATE_W-1-COL_W*c -: COL_W];
              if (bypass) result_cols[c] <= state_in[STATE_W-1-COL_W*c -: COL_W];
            end
          end
        end
        BUSY: begin
          for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
            result_cols[mix_idx[k]] <= mixed[k];
          end
          col_cnt <= col_cnt + CNT_W'(COLS_PER_CYCLE);
        end
        default: ;
      endcase
    end
  end

  assign state_out = {result_cols[0], result_cols[1], result_cols[2], result_cols[3]};

endmodule
